// File: rtl/mem_flash_txn_fsm.sv
// Flash transaction sequencer: expands one read/program request into the
// WREN/CMD/ADDR/DUMMY/DATA byte sequence for a byte-level SPI controller.
module mem_flash_txn_fsm #(
  parameter int unsigned LEN_W     = 6,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_QREAD = 8'h6B,
  parameter logic [7:0]  CMD_PP    = 8'h02,
  parameter logic [7:0]  CMD_QPP   = 8'h32,
  parameter logic [7:0]  CMD_WREN  = 8'h06
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic             req_quad,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             spi_start,
  output logic             spi_r_w,
  output logic             spi_quad,
  output logic [7:0]       spi_tx_data,
  output logic             spi_tx_valid,
  input  logic             spi_tx_ready,
  input  logic             spi_busy,
  input  logic             spi_done,
  input  logic             spi_rx_valid,
  input  logic [7:0]       spi_rx_data,
  output logic             spi_rx_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_FIN
  } state_e;

  typedef enum logic [1:0] {P_ISSUE, P_WAIT, P_GAP} phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic             write_q, write_d;
  logic             quad_q, quad_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       aidx_q, aidx_d;
  logic             zlen_q, zlen_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic       start_s, wr_ready_s, rx_ack_s, rw_s, quad_s;
  logic [7:0] tx_s, opcode_s;
  logic       ctl_free_s, data_ok_s, last_s, drain_s;

  // State, request latches and read-data holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= P_ISSUE;
      write_q    <= 1'b0;
      quad_q     <= 1'b0;
      addr_q     <= 24'h000000;
      cnt_q      <= {LEN_W{1'b0}};
      aidx_q     <= 2'd0;
      zlen_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      write_q    <= write_d;
      quad_q     <= quad_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      aidx_q     <= aidx_d;
      zlen_q     <= zlen_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next-state, per-byte sub-phase sequencing and SPI byte selection
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    write_d    = write_q;
    quad_d     = quad_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    aidx_d     = aidx_q;
    zlen_d     = zlen_q;
    rd_data_d  = rd_data_q;
    start_s    = 1'b0;
    wr_ready_s = 1'b0;
    rx_ack_s   = 1'b0;
    rw_s       = 1'b0;
    quad_s     = 1'b0;
    tx_s       = 8'h00;
    opcode_s   = write_q ? (quad_q ? CMD_QPP : CMD_PP) : (quad_q ? CMD_QREAD : CMD_READ);
    ctl_free_s = spi_tx_ready && !spi_busy && !spi_done;
    last_s     = (cnt_q == LEN_W'(1));
    // A read DATA phase with the counter exhausted is only waiting for the last handshake
    drain_s    = (state_q == S_DATA) && (cnt_q == {LEN_W{1'b0}});

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = rd_valid_q;
    end

    case (state_q)
      S_WREN:  tx_s = CMD_WREN;
      S_CMD:   tx_s = opcode_s;
      S_ADDR: begin
        case (aidx_q)
          2'd0:    tx_s = addr_q[23:16];
          2'd1:    tx_s = addr_q[15:8];
          default: tx_s = addr_q[7:0];
        endcase
      end
      S_DATA: begin
        tx_s   = write_q ? wr_data : 8'h00;
        rw_s   = !write_q;
        quad_s = quad_q;
      end
      default: tx_s = 8'h00;
    endcase

    if (state_q == S_DATA) begin
      data_ok_s = write_q ? wr_valid : !rd_valid_q;
    end else begin
      data_ok_s = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          quad_d  = req_quad;
          addr_d  = req_addr;
          cnt_d   = req_len;
          aidx_d  = 2'd0;
          phase_d = P_ISSUE;
          if (req_len == {LEN_W{1'b0}}) begin
            state_d = S_FIN;
            zlen_d  = 1'b1;
          end else begin
            state_d = req_write ? S_WREN : S_CMD;
            zlen_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        zlen_d  = 1'b0;
      end
      S_WREN, S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        case (phase_q)
          P_ISSUE: begin
            if (drain_s) begin
              if (!rd_valid_q || rd_ready) begin
                state_d = S_FIN;
              end else begin
                state_d = S_DATA;
              end
            end else if (ctl_free_s && data_ok_s) begin
              start_s    = 1'b1;
              wr_ready_s = (state_q == S_DATA) && write_q;
              phase_d    = P_WAIT;
            end else begin
              phase_d = P_ISSUE;
            end
          end
          P_WAIT: begin
            if (spi_done) begin
              phase_d = P_GAP;
              if ((state_q == S_DATA) && !write_q && spi_rx_valid) begin
                rd_data_d  = spi_rx_data;
                rd_valid_d = 1'b1;
                rx_ack_s   = 1'b1;
              end else begin
                rd_data_d = rd_data_q;
              end
            end else begin
              phase_d = P_WAIT;
            end
          end
          P_GAP: begin
            if (!spi_done) begin
              phase_d = P_ISSUE;
              case (state_q)
                S_WREN: state_d = S_CMD;
                S_CMD: begin
                  state_d = S_ADDR;
                  aidx_d  = 2'd0;
                end
                S_ADDR: begin
                  if (aidx_q == 2'd2) begin
                    state_d = (quad_q && !write_q) ? S_DUMMY : S_DATA;
                  end else begin
                    aidx_d = aidx_q + 2'd1;
                  end
                end
                S_DUMMY: state_d = S_DATA;
                S_DATA: begin
                  cnt_d = cnt_q - LEN_W'(1);
                  if (last_s && write_q) begin
                    state_d = S_FIN;
                  end else begin
                    state_d = S_DATA;
                  end
                end
                default: state_d = S_IDLE;
              endcase
            end else begin
              phase_d = P_GAP;
            end
          end
          default: phase_d = P_ISSUE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE) && !zlen_q;
  assign done         = (state_q == S_FIN);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign wr_ready     = wr_ready_s;
  assign spi_start    = start_s;
  assign spi_tx_valid = start_s;
  assign spi_r_w      = rw_s;
  assign spi_quad     = quad_s;
  assign spi_tx_data  = tx_s;
  assign spi_rx_ready = rx_ack_s;

endmodule
